// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the MIPS register-file write port among NUM_REQ writers.
// The granted write is registered onto A3/WD3/WE3; read-after-write hazards are flagged on A1/A2.
module regfile_write_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_REGISTERS = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = $clog2(NUM_REGISTERS),
    parameter int ID_WIDTH      = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         A3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic                          WE3,
    output logic [ID_WIDTH-1:0]           grant_id,
    input  logic [ADDR_WIDTH-1:0]         A1,
    input  logic [ADDR_WIDTH-1:0]         A2,
    output logic                          hazard1,
    output logic                          hazard2
);

    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   win;
    logic                  found;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Scan req_valid starting at ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[ID_WIDTH'(idx)]) begin
                found = 1'b1;
                win   = ID_WIDTH'(idx);
            end
        end
    end

    // Gating with rst_n keeps req_ready low while the block is held in reset.
    assign grant     = found && !hold && rst_n;
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
    assign win_addr  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data  = req_data[win*DATA_WIDTH +: DATA_WIDTH];

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            A3       <= '0;
            WD3      <= '0;
            WE3      <= 1'b0;
            grant_id <= '0;
        end else if (grant) begin
            A3       <= win_addr;
            WD3      <= win_data;
            WE3      <= (win_addr != '0);
            grant_id <= win;
            ptr      <= (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + ID_WIDTH'(1);
        end else begin
            WE3      <= 1'b0;
        end
    end

    // $zero is hardwired, so a read of register 0 never sees stale data.
    assign hazard1 = WE3 && (A1 == A3) && (A1 != '0);
    assign hazard2 = WE3 && (A2 == A3) && (A2 != '0);

endmodule
